sqrt_scheduler: RTL and testbench
=================================

Name: sqrt_scheduler

Overview:
- Shares one iterative square-root datapath between N_REQ requesters, e.g. the scale/weight channels of the baggage-drop station.
- Round-robin arbitration; the winner's 8-bit operand is captured on grant.
- The 8.8 fixed-point root is computed one result bit per cycle, MSB first.
- A one-cycle valid pulse returns the result tagged with the requester ID.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of out_id; must satisfy 2^ID_W >= N_REQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req  in  N_REQ  per-requester request level.
- in_bus  in  8*N_REQ  operands; requester k drives bits [8k+7:8k].
- grant  out  N_REQ  one-hot, one-cycle pulse to the winning requester.
- busy  out  1  high from grant through the valid pulse.
- out_valid  out  1  one-cycle result strobe.
- out_id  out  ID_W  index of the requester owning out.
- out  out  16  result, 8.8 unsigned fixed point.

Behaviour:
- Reset (async, immediate): state=IDLE, grant=0, busy=0, out_valid=0, out_id=0, out=0, rr pointer=0, internal y=0.
- Reset mid-computation aborts the operation: no out_valid, no partial result on out.

- States: IDLE, ITER, DONE.

- IDLE:
  - If req != 0, at the clock edge:
    - Select the first asserted req at or after the rr pointer, wrapping modulo N_REQ.
    - Capture that requester's in_bus slice into opnd and its index into cur_id.
    - Register grant=onehot(cur_id) for exactly one cycle.
    - Set busy=1, y=0, bit index=15.
    - Go to ITER.
  - If req == 0, stay in IDLE; grant=0, busy=0.

- ITER (16 cycles, bit index 15 down to 0), per cycle:
  - trial = y | (1<<idx).
  - If trial*trial (32-bit) <= opnd*65536, then y = trial; otherwise y is unchanged.
  - After idx=0, go to DONE and register out=y, out_id=cur_id, out_valid=1.

- DONE (1 cycle):
  - out_valid=1 in this cycle only.
  - On exit: rr pointer = (cur_id+1) mod N_REQ, busy=0, go to IDLE.
  - out and out_id hold their values until the next DONE.

- Result rule: out = floor(sqrt(opnd)*256), i.e. the largest y with y*y <= opnd*2^16. This is exact; no rounding.

- Timing:
  - grant rises 1 cycle after req is sampled in IDLE.
  - out_valid rises 16 cycles after grant rises.
  - Issue period is 18 cycles per operation when requests are back-to-back.

- Handshake:
  - A requester holds req and its operand until it sees grant, then drops req.
  - req still high in the cycle after grant counts as a new request, arbitrated normally on return to IDLE.
  - req dropped before grant is a withdrawal; no result is produced for it.
  - req and in_bus changes during ITER/DONE are ignored; the operand is frozen in opnd.

- Simultaneous requests: exactly one grant per operation; the others wait.
  - Fairness: every continuously asserted requester is granted within N_REQ operations.
- N_REQ=1: pointer stays 0 and arbitration degenerates to a pass-through.
- Width rules: the compare uses a 32-bit unsigned product against {opnd,16'h0000}; no truncation is permitted.

Test Plan:
- Reset, then req=4'b0001 with in_bus[7:0]=4 → grant=4'b0001 for 1 cycle; out_valid 16 cycles later with out=16'h0200, out_id=0.
- Single requests with operands 0, 1, 2, 9, 255 → out = 16'h0000, 16'h0100, 16'h016A, 16'h0300, 16'h0FF7.
- req=4'b1111 held continuously with distinct operands → grants in order 0,1,2,3,0; each out_id matches its grant; results are spaced 18 cycles apart.
- req=4'b0100 granted, then req=4'b0101 → next grant goes to 0 (pointer at 3, wraps); the following grant goes to 2.
- Assert rst 5 cycles into ITER → all outputs go to 0 immediately; no out_valid appears; the first grant after release goes to requester 0.
- Change in_bus of the granted requester during ITER → result still reflects the operand captured at grant; busy stays 1 from grant through DONE, then falls.

Source files
------------

// File: rtl/sqrt_scheduler.sv
// Round-robin arbiter feeding one shared bit-serial 8.8 square-root unit.
// Each grant captures an 8-bit operand; the result is returned with the requester id.
module sqrt_scheduler #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   in_bus,
   output logic [N_REQ-1:0]     grant,
   output logic                 busy,
   output logic                 out_valid,
   output logic [ID_W-1:0]      out_id,
   output logic [15:0]          out
);

   localparam int unsigned OP_W  = 8;
   localparam int unsigned RES_W = 16;
   localparam int unsigned IDX_W = 4;
   localparam int unsigned SQ_W  = 32;

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t                state, state_nxt;
   logic [ID_W-1:0]       rr;
   logic [ID_W-1:0]       cur_id;
   logic [OP_W-1:0]       opnd;
   logic [RES_W-1:0]      y;
   logic [IDX_W-1:0]      idx;

   logic [ID_W-1:0]       win_id;
   logic                  win_found;
   logic [RES_W-1:0]      trial;
   logic [SQ_W-1:0]       trial_sq;
   logic [RES_W-1:0]      y_nxt;

   // First asserted request at or after the rr pointer, wrapping.
   always_comb begin
      int unsigned k;
      win_id    = '0;
      win_found = 1'b0;
      k         = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         k = (32'(rr) + i) % N_REQ;
         if (!win_found && req[k]) begin
            win_found = 1'b1;
            win_id    = ID_W'(k);
         end
      end
   end

   // One result bit per cycle: keep the trial bit if trial^2 fits under opnd*2^16.
   always_comb begin
      trial    = y | (RES_W'(1) << idx);
      trial_sq = SQ_W'(trial) * SQ_W'(trial);
      y_nxt    = (trial_sq <= SQ_W'({opnd, 16'h0000})) ? trial : y;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_found) state_nxt = ITER;
         ITER:    if (idx == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant     <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_id    <= '0;
         out       <= '0;
         rr        <= '0;
         cur_id    <= '0;
         opnd      <= '0;
         y         <= '0;
         idx       <= '0;
      end else begin
         grant     <= '0;
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  opnd   <= in_bus[32'(win_id)*OP_W +: OP_W];
                  cur_id <= win_id;
                  grant  <= N_REQ'(1) << win_id;
                  busy   <= 1'b1;
                  y      <= '0;
                  idx    <= IDX_W'(RES_W - 1);
               end else begin
                  busy   <= 1'b0;
               end
            end
            ITER: begin
               y   <= y_nxt;
               idx <= idx - IDX_W'(1);
               if (idx == '0) begin
                  out       <= y_nxt;
                  out_id    <= cur_id;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               busy <= 1'b0;
               rr   <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + ID_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Directed bench for sqrt_scheduler: arbitration order, latency, results, abort.
module tb_sqrt_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] in_bus;
   logic [3:0]  grant;
   logic        busy;
   logic        out_valid;
   logic [1:0]  out_id;
   logic [15:0] out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   sqrt_scheduler #(.N_REQ(4), .ID_W(2)) dut (
      .clk(clk), .rst(rst), .req(req), .in_bus(in_bus), .grant(grant),
      .busy(busy), .out_valid(out_valid), .out_id(out_id), .out(out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      req = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Wait for a grant, then follow the operation through its valid pulse.
   task automatic run_op(input logic [3:0] exp_grant, input logic [1:0] exp_id,
                         input logic [15:0] exp_out, input bit drop, input bit chg,
                         output int vcyc);
      bit got;
      int n, busy_low, extra;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         if (grant != '0) got = 1'b1;
      end
      chk("grant", 32'(grant), 32'(exp_grant));
      chk("busy_at_grant", 32'(busy), 32'd1);
      if (drop) req = req & ~grant;
      if (chg)  in_bus = ~in_bus;
      n = 0; got = 1'b0; busy_low = 0; extra = 0;
      while (!got && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (grant != '0) extra++;
         if (!busy) busy_low++;
         if (out_valid) got = 1'b1;
      end
      chk("latency", 32'(n), 32'd16);
      chk("out", 32'(out), 32'(exp_out));
      chk("out_id", 32'(out_id), 32'(exp_id));
      chk("busy_held", 32'(busy_low), 32'd0);
      chk("grant_pulse", 32'(extra), 32'd0);
      vcyc = cyc;
      @(posedge clk); #1;
      chk("valid_pulse", 32'(out_valid), 32'd0);
      chk("busy_end", 32'(busy), 32'd0);
   endtask

   logic [7:0]  sing_op  [5] = '{8'd0, 8'd1, 8'd2, 8'd9, 8'd255};
   logic [15:0] sing_exp [5] = '{16'h0000, 16'h0100, 16'h016A, 16'h0300, 16'h0FF7};
   logic [15:0] rr_exp   [4] = '{16'h0400, 16'h0500, 16'h0600, 16'h0700};

   initial begin
      int v, prev, seen;
      in_bus = '0;
      do_reset();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_id", 32'(out_id), 32'd0);

      // Basic operation: sqrt(4) = 2.0
      in_bus[7:0] = 8'd4;
      req = 4'b0001;
      run_op(4'b0001, 2'd0, 16'h0200, 1'b1, 1'b0, v);

      for (int i = 0; i < 5; i++) begin
         in_bus[7:0] = sing_op[i];
         req = 4'b0001;
         run_op(4'b0001, 2'd0, sing_exp[i], 1'b1, 1'b0, v);
      end

      // Operand frozen at grant even if the bus changes during ITER
      in_bus = 32'h0000_0064;
      req = 4'b0001;
      run_op(4'b0001, 2'd0, 16'h0A00, 1'b1, 1'b1, v);

      // Continuous requests rotate 0,1,2,3,0 at an 18-cycle issue period
      do_reset();
      in_bus = {8'd49, 8'd36, 8'd25, 8'd16};
      req = 4'b1111;
      prev = 0;
      for (int i = 0; i < 5; i++) begin
         run_op(4'(1 << (i % 4)), 2'(i % 4), rr_exp[i % 4], 1'b0, 1'b0, v);
         if (i > 0) chk("spacing", 32'(v - prev), 32'd18);
         prev = v;
      end
      req = '0;

      // Pointer after granting 2 sits at 3 and wraps to 0
      do_reset();
      in_bus = {8'd49, 8'd36, 8'd25, 8'd16};
      req = 4'b0100;
      run_op(4'b0100, 2'd2, 16'h0600, 1'b1, 1'b0, v);
      req = 4'b0101;
      run_op(4'b0001, 2'd0, 16'h0400, 1'b1, 1'b0, v);
      run_op(4'b0100, 2'd2, 16'h0600, 1'b1, 1'b0, v);

      // Reset five cycles into ITER aborts the operation
      in_bus[23:16] = 8'd200;
      req = 4'b0100;
      seen = 0;
      for (int i = 0; i < 40 && grant == '0; i++) begin
         @(posedge clk); #1;
      end
      chk("abort_grant", 32'(grant), 32'b0100);
      req = '0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_grant0", 32'(grant), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_out", 32'(out), 32'd0);
      chk("abort_id", 32'(out_id), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (out_valid || busy || grant != '0) seen++;
      end
      chk("abort_quiet", 32'(seen), 32'd0);
      in_bus[7:0] = 8'd9;
      req = 4'b0101;
      run_op(4'b0001, 2'd0, 16'h0300, 1'b1, 1'b0, v);
      run_op(4'b0100, 2'd2, 16'h0E24, 1'b1, 1'b0, v);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
